// File: rtl/bpm_controller_if.sv
// ----------------------------------------------------------------------------
// bpm_controller_if
// Groups the two handshakes of the BPM controller:
//   calculator side : bpm_value / bpm_valid in, bpm_copied acknowledge out
//   display side    : avg_bpm / avg_valid out, avg_ready in
// Modports:
//   master - the controller (consumes bpm_*, produces avg_*)
//   slave  - the environment (calculator plus downstream display/UART)
// ----------------------------------------------------------------------------
interface bpm_controller_if;
  logic [7:0] bpm_value;
  logic       bpm_valid;
  logic       bpm_copied;
  logic [7:0] avg_bpm;
  logic       avg_valid;
  logic       avg_ready;

  modport master (
    input  bpm_value, bpm_valid, avg_ready,
    output bpm_copied, avg_bpm, avg_valid
  );

  modport slave (
    output bpm_value, bpm_valid, avg_ready,
    input  bpm_copied, avg_bpm, avg_valid
  );
endinterface

// File: rtl/bpm_controller.sv
// ----------------------------------------------------------------------------
// bpm_controller
// Sequences the BPM calculator, acknowledges each result, rejects out-of-range
// readings as artifacts, keeps a 4-deep moving average and hands the average
// to the display/UART stage. Flags loss of pulse after TIMEOUT_TICKS sample
// ticks without an accepted beat.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   sample_tick   25 Hz strobe driving the loss-of-pulse counter
//   start, stop   one-cycle measurement requests (stop wins)
//   calc_en       enable to the calculator
//   bus           calculator and display handshakes (master modport)
//   no_pulse      loss-of-pulse flag
//   overrun       sticky: an unaccepted average was overwritten
//   artifact_cnt  saturating count of rejected readings
// ----------------------------------------------------------------------------
module bpm_controller #(
  parameter int BPM_MIN       = 30,
  parameter int BPM_MAX       = 220,
  parameter int TIMEOUT_TICKS = 75,
  parameter int TWIDTH        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              start,
  input  logic              stop,
  output logic              calc_en,
  bpm_controller_if.master  bus,
  output logic              no_pulse,
  output logic              overrun,
  output logic [7:0]        artifact_cnt
);

  localparam logic [7:0]        MIN_C   = 8'(BPM_MIN);
  localparam logic [7:0]        MAX_C   = 8'(BPM_MAX);
  // The tick that moves the counter from TIMEOUT_TICKS-1 is the timeout tick.
  localparam logic [TWIDTH-1:0] TLAST_C = TWIDTH'(TIMEOUT_TICKS - 1);
  localparam logic [TWIDTH-1:0] TONE_C  = TWIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              calc_en_r;

  // cap_vld_r is both the bpm_copied acknowledge and the valid bit of the
  // one-cycle capture stage; cap_val_r is processed while it is high.
  logic              cap_vld_r;
  logic [7:0]        cap_val_r;

  logic [7:0]        ring_r [4];
  logic [1:0]        wr_ptr_r;
  logic [2:0]        fill_r;
  logic [TWIDTH-1:0] tcnt_r;
  logic [7:0]        avg_bpm_r;
  logic              avg_valid_r;
  logic              no_pulse_r;
  logic              overrun_r;
  logic [7:0]        artifact_r;

  logic              capture_s;
  logic              active_s;
  logic              in_range_s;
  logic              proc_s;
  logic              accept_s;
  logic              reject_s;
  logic              tick_s;
  logic              timeout_s;
  logic              load_s;
  logic [2:0]        fill_nx_s;
  logic [9:0]        sum_s;

  // Qualify the captured reading and derive the per-cycle datapath controls.
  always_comb begin
    capture_s  = bus.bpm_valid && !cap_vld_r;
    active_s   = (state_r != ST_IDLE);
    in_range_s = (cap_val_r >= MIN_C) && (cap_val_r <= MAX_C);
    // Readings captured while idle are acknowledged but never processed.
    proc_s     = cap_vld_r && active_s;
    accept_s   = proc_s && in_range_s;
    reject_s   = proc_s && !in_range_s;
    tick_s     = sample_tick && active_s;
    // An accepted beat in the same cycle beats the timeout.
    timeout_s  = tick_s && !accept_s && (tcnt_r == TLAST_C);
    if (fill_r == 3'd4) begin
      fill_nx_s = 3'd4;
    end else begin
      fill_nx_s = fill_r + 3'd1;
    end
    load_s     = accept_s && (fill_nx_s == 3'd4);
  end

  // Sum of the ring with the incoming sample standing in for the slot it
  // overwrites, so the average already includes the new beat.
  always_comb begin
    sum_s = 10'd0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == wr_ptr_r) begin
        sum_s = sum_s + {2'b00, cap_val_r};
      end else begin
        sum_s = sum_s + {2'b00, ring_r[i]};
      end
    end
  end

  // Next-state logic; stop overrides everything including start.
  always_comb begin
    state_nx_s = state_r;
    if (stop) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nx_s = ST_ARMED;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (load_s) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_RUN: begin
          if (timeout_s) begin
            state_nx_s = ST_ARMED;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register with a registered calculator enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      calc_en_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      calc_en_r <= (state_nx_s != ST_IDLE);
    end
  end

  // Capture stage: acknowledge each new result for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld_r <= 1'b0;
      cap_val_r <= 8'd0;
    end else begin
      cap_vld_r <= capture_s;
      if (capture_s) begin
        cap_val_r <= bus.bpm_value;
      end
    end
  end

  // History, timeout, status flags and the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ring_r[i] <= 8'd0;
      end
      wr_ptr_r    <= 2'd0;
      fill_r      <= 3'd0;
      tcnt_r      <= '0;
      avg_bpm_r   <= 8'd0;
      avg_valid_r <= 1'b0;
      no_pulse_r  <= 1'b0;
      overrun_r   <= 1'b0;
      artifact_r  <= 8'd0;
    end else if (stop) begin
      // Status flags and the artifact count survive a stop for inspection.
      for (int i = 0; i < 4; i++) begin
        ring_r[i] <= 8'd0;
      end
      wr_ptr_r    <= 2'd0;
      fill_r      <= 3'd0;
      tcnt_r      <= '0;
      avg_valid_r <= 1'b0;
    end else if (start && (state_r == ST_IDLE)) begin
      for (int i = 0; i < 4; i++) begin
        ring_r[i] <= 8'd0;
      end
      wr_ptr_r    <= 2'd0;
      fill_r      <= 3'd0;
      tcnt_r      <= '0;
      avg_valid_r <= 1'b0;
      no_pulse_r  <= 1'b0;
      overrun_r   <= 1'b0;
      artifact_r  <= 8'd0;
    end else begin
      if (accept_s) begin
        ring_r[wr_ptr_r] <= cap_val_r;
        wr_ptr_r         <= wr_ptr_r + 2'd1;
        fill_r           <= fill_nx_s;
        tcnt_r           <= '0;
        no_pulse_r       <= 1'b0;
      end else if (timeout_s) begin
        for (int i = 0; i < 4; i++) begin
          ring_r[i] <= 8'd0;
        end
        wr_ptr_r   <= 2'd0;
        fill_r     <= 3'd0;
        tcnt_r     <= '0;
        no_pulse_r <= 1'b1;
      end else if (tick_s) begin
        tcnt_r <= tcnt_r + TONE_C;
      end

      if (reject_s && (artifact_r != 8'hFF)) begin
        artifact_r <= artifact_r + 8'd1;
      end

      if (load_s) begin
        avg_bpm_r   <= sum_s[9:2];
        avg_valid_r <= 1'b1;
        // Overwriting an average nobody took is recorded; a same-edge
        // transfer of the old value is not an overrun.
        if (avg_valid_r && !bus.avg_ready) begin
          overrun_r <= 1'b1;
        end
      end else if (timeout_s) begin
        avg_valid_r <= 1'b0;
      end else if (avg_valid_r && bus.avg_ready) begin
        avg_valid_r <= 1'b0;
      end
    end
  end

  assign calc_en        = calc_en_r;
  assign bus.bpm_copied = cap_vld_r;
  assign bus.avg_bpm    = avg_bpm_r;
  assign bus.avg_valid  = avg_valid_r;
  assign no_pulse       = no_pulse_r;
  assign overrun        = overrun_r;
  assign artifact_cnt   = artifact_r;

endmodule

// File: tb/tb_bpm_controller.sv
// ----------------------------------------------------------------------------
// tb_bpm_controller
// Directed walk through the controller's behaviour followed by a randomized
// stretch. A queue-based reference model of the averaging/handshake rules is
// advanced on every clock edge and every output is compared after each edge.
// ----------------------------------------------------------------------------
module tb_bpm_controller;
  localparam int TIMEOUT = 75;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       start;
  logic       stop;
  logic       calc_en;
  logic       no_pulse;
  logic       overrun;
  logic [7:0] artifact_cnt;

  bpm_controller_if bus();

  bpm_controller #(
    .BPM_MIN(30), .BPM_MAX(220), .TIMEOUT_TICKS(TIMEOUT), .TWIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .start(start),
    .stop(stop), .calc_en(calc_en), .bus(bus), .no_pulse(no_pulse),
    .overrun(overrun), .artifact_cnt(artifact_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_on;
  int hist[$];
  int m_tcnt;
  int m_copied;
  int m_cap;
  int m_avg;
  int m_avg_valid;
  int m_np;
  int m_ovr;
  int m_art;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_on = 0; hist.delete(); m_tcnt = 0; m_copied = 0; m_cap = 0;
    m_avg = 0; m_avg_valid = 0; m_np = 0; m_ovr = 0; m_art = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input int v, input int val, input int tk,
                            input int rdy, input int st, input int sp);
    int proc, pcap, old_valid, loaded, tmo, accepted, s, nc;
    proc = m_copied & m_on; pcap = m_cap; old_valid = m_avg_valid;
    loaded = 0; tmo = 0;
    if (sp != 0) begin
      m_on = 0; hist.delete(); m_tcnt = 0; m_avg_valid = 0;
    end else if (st != 0 && m_on == 0) begin
      m_on = 1; hist.delete(); m_tcnt = 0; m_np = 0; m_ovr = 0; m_art = 0;
      m_avg_valid = 0;
    end else begin
      accepted = (proc != 0 && pcap >= 30 && pcap <= 220) ? 1 : 0;
      if (proc != 0 && accepted == 0 && m_art < 255) m_art++;
      if (accepted != 0) begin
        hist.push_back(pcap);
        if (hist.size() > 4) void'(hist.pop_front());
        m_tcnt = 0; m_np = 0;
        if (hist.size() == 4) begin
          s = 0;
          foreach (hist[i]) s += hist[i];
          loaded = 1;
          if (old_valid != 0 && rdy == 0) m_ovr = 1;
          m_avg = s / 4;
          m_avg_valid = 1;
        end
      end else if (tk != 0 && m_on != 0) begin
        m_tcnt++;
        if (m_tcnt == TIMEOUT) begin
          tmo = 1; m_np = 1; hist.delete(); m_tcnt = 0; m_avg_valid = 0;
        end
      end
      if (loaded == 0 && tmo == 0 && old_valid != 0 && rdy != 0) m_avg_valid = 0;
    end
    nc = (v != 0 && m_copied == 0) ? 1 : 0;
    if (nc != 0) m_cap = val;
    m_copied = nc;
  endtask

  task automatic check_all();
    check("calc_en",      32'(calc_en),        32'(m_on));
    check("bpm_copied",   32'(bus.bpm_copied), 32'(m_copied));
    check("avg_bpm",      32'(bus.avg_bpm),    32'(m_avg));
    check("avg_valid",    32'(bus.avg_valid),  32'(m_avg_valid));
    check("no_pulse",     32'(no_pulse),       32'(m_np));
    check("overrun",      32'(overrun),        32'(m_ovr));
    check("artifact_cnt", 32'(artifact_cnt),   32'(m_art));
  endtask

  // One clock: snapshot inputs, edge, update model, sample #1 later.
  task automatic cycle();
    int v, val, tk, rdy, st, sp;
    v = 32'(bus.bpm_valid); val = 32'(bus.bpm_value); tk = 32'(sample_tick);
    rdy = 32'(bus.avg_ready); st = 32'(start); sp = 32'(stop);
    @(posedge clk);
    model_edge(v, val, tk, rdy, st, sp);
    #1;
    check_all();
  endtask

  // One calculator result: valid for one edge, dropped while acknowledged.
  task automatic beat(input int v);
    bus.bpm_valid = 1'b1; bus.bpm_value = 8'(v);
    cycle();
    check("copied_hi", 32'(bus.bpm_copied), 32'd1);
    bus.bpm_valid = 1'b0;
    cycle();
    check("copied_lo", 32'(bus.bpm_copied), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  initial begin
    int quiet;
    rst = 1'b1; sample_tick = 1'b0; start = 1'b0; stop = 1'b0;
    bus.bpm_valid = 1'b0; bus.bpm_value = 8'd0; bus.avg_ready = 1'b0;
    m_reset();
    #2;
    check_all();
    @(negedge clk); rst = 1'b0;
    cycle();

    // Fill the history; only the 4th beat produces 63, then 70 gives 65.
    pulse_start();
    check("start_en", 32'(calc_en), 32'd1);
    beat(60); check("arm_v1", 32'(bus.avg_valid), 32'd0);
    beat(62); check("arm_v2", 32'(bus.avg_valid), 32'd0);
    beat(64); check("arm_v3", 32'(bus.avg_valid), 32'd0);
    beat(66);
    check("avg63_v", 32'(bus.avg_valid), 32'd1);
    check("avg63",   32'(bus.avg_bpm),   32'd63);
    beat(70);
    check("avg65",   32'(bus.avg_bpm),   32'd65);
    check("ovr_set", 32'(overrun),       32'd1);

    // Stop keeps overrun; start clears it.
    stop = 1'b1; cycle(); stop = 1'b0;
    check("stop_en",   32'(calc_en),       32'd0);
    check("stop_av",   32'(bus.avg_valid), 32'd0);
    check("stop_ovr",  32'(overrun),       32'd1);
    pulse_start();
    check("restart_ovr", 32'(overrun), 32'd0);

    // Load coinciding with avg_ready: transfer plus new value, no overrun.
    beat(100); beat(100); beat(100); beat(100);
    check("avg100", 32'(bus.avg_bpm), 32'd100);
    bus.bpm_valid = 1'b1; bus.bpm_value = 8'd104;
    cycle();
    bus.bpm_valid = 1'b0; bus.avg_ready = 1'b1;
    cycle();
    check("coin_avg", 32'(bus.avg_bpm),   32'd101);
    check("coin_v",   32'(bus.avg_valid), 32'd1);
    check("coin_ovr", 32'(overrun),       32'd0);
    cycle();
    check("xfer_v", 32'(bus.avg_valid), 32'd0);
    bus.avg_ready = 1'b0;

    // Artifacts leave history alone.
    beat(250); beat(20);
    check("art2",    32'(artifact_cnt),  32'd2);
    check("art_av",  32'(bus.avg_valid), 32'd0);
    beat(108);
    check("avg103",  32'(bus.avg_bpm),   32'd103);

    // Loss of pulse after 75 ticks, pending average dropped.
    sample_tick = 1'b1;
    repeat (TIMEOUT - 1) cycle();
    check("pre_to_np", 32'(no_pulse),      32'd0);
    check("pre_to_av", 32'(bus.avg_valid), 32'd1);
    cycle();
    sample_tick = 1'b0;
    check("to_np", 32'(no_pulse),      32'd1);
    check("to_av", 32'(bus.avg_valid), 32'd0);
    check("to_en", 32'(calc_en),       32'd1);
    beat(80);
    check("np_clr", 32'(no_pulse),      32'd0);
    check("re_v1",  32'(bus.avg_valid), 32'd0);
    beat(80); beat(80);
    check("re_v3",  32'(bus.avg_valid), 32'd0);
    beat(80);
    check("re_avg", 32'(bus.avg_bpm),   32'd80);

    // Stop with a pending result and a pending average.
    bus.bpm_valid = 1'b1; bus.bpm_value = 8'd250; stop = 1'b1;
    cycle();
    check("stp_en", 32'(calc_en),        32'd0);
    check("stp_av", 32'(bus.avg_valid),  32'd0);
    check("stp_cp", 32'(bus.bpm_copied), 32'd1);
    bus.bpm_valid = 1'b0; stop = 1'b0;
    cycle();
    check("stp_cp0", 32'(bus.bpm_copied), 32'd0);
    check("stp_art", 32'(artifact_cnt),   32'd2);

    // Start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("ss_en", 32'(calc_en), 32'd0);
    cycle();

    // Asynchronous reset in RUN while bpm_copied is high.
    pulse_start();
    beat(90); beat(91); beat(92); beat(93);
    bus.bpm_valid = 1'b1; bus.bpm_value = 8'd94;
    cycle();
    check("pre_rst_cp", 32'(bus.bpm_copied), 32'd1);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("rst_en",  32'(calc_en),        32'd0);
    check("rst_cp",  32'(bus.bpm_copied), 32'd0);
    check("rst_avg", 32'(bus.avg_bpm),    32'd0);
    check("rst_av",  32'(bus.avg_valid),  32'd0);
    check("rst_np",  32'(no_pulse),       32'd0);
    check("rst_ovr", 32'(overrun),        32'd0);
    check("rst_art", 32'(artifact_cnt),   32'd0);
    bus.bpm_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    cycle();

    // Randomized stretch, alternating busy and sparse-beat phases.
    pulse_start();
    for (int n = 0; n < 3000; n++) begin
      quiet = ((n / 500) % 2 == 1) ? 1 : 0;
      if (quiet != 0) begin
        bus.bpm_valid = ($urandom_range(0, 299) == 0);
        sample_tick   = ($urandom_range(0, 1) == 1);
      end else begin
        bus.bpm_valid = ($urandom_range(0, 1) == 1);
        sample_tick   = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 9) < 7) begin
        bus.bpm_value = 8'($urandom_range(30, 220));
      end else begin
        bus.bpm_value = 8'($urandom_range(0, 255));
      end
      bus.avg_ready = ($urandom_range(0, 1) == 1);
      start         = ($urandom_range(0, 99) == 0);
      stop          = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpm_controller.md
# bpm_controller

Sequencing and post-processing controller for the BPM datapath. It enables the BPM calculator and consumes each `bpm_value` through the `bpm_valid`/`bpm_copied` handshake. It rejects out-of-range readings as artifacts and keeps a 4-deep moving average. The averaged BPM goes to the downstream display/UART stage over a valid/ready handshake, and the block flags loss of pulse after a programmable number of 25 Hz sample ticks without an accepted beat.

## Interface
Parameters:
- `BPM_MIN`, default 30: lowest accepted BPM, inclusive.
- `BPM_MAX`, default 220: highest accepted BPM, inclusive.
- `TIMEOUT_TICKS`, default 75: sample ticks (3 s at 25 Hz) without an accepted beat before `no_pulse`.
- `TWIDTH`, default 8: timeout counter width; must satisfy TIMEOUT_TICKS < 2^TWIDTH.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe at the 25 Hz downsampled rate.
- `start`  in  1  one-cycle request to begin measuring.
- `stop`  in  1  one-cycle request to end measuring.
- `calc_en`  out  1  enable to the BPM calculator.
- `bpm_value`  in  8  calculator result.
- `bpm_valid`  in  1  calculator result valid.
- `bpm_copied`  out  1  one-cycle acknowledge to the calculator.
- `avg_bpm`  out  8  averaged BPM.
- `avg_valid`  out  1  `avg_bpm` valid; held until `avg_ready`.
- `avg_ready`  in  1  downstream accepts `avg_bpm`.
- `no_pulse`  out  1  timeout flag.
- `overrun`  out  1  sticky: an unaccepted average was overwritten.
- `artifact_cnt`  out  8  saturating count of rejected readings.

## Operation
- States:
  - IDLE, the reset state: `calc_en`=0.
  - ARMED: `calc_en`=1; fewer than 4 accepted samples held.
  - RUN: `calc_en`=1; history full, and an average is produced on each accepted sample.
- Transitions:
  - IDLE→ARMED on `start`. History, fill count, timeout counter, `no_pulse`, `overrun` and `artifact_cnt` are all cleared.
  - ARMED→RUN when the 4th sample is accepted.
  - RUN→ARMED on timeout.
  - Any state→IDLE on `stop`. `stop` has priority over `start` in the same cycle.
- Capture condition: `bpm_valid`=1 and `bpm_copied`=0. On a capture, `bpm_copied` pulses high for exactly one cycle. `bpm_valid` is ignored while `bpm_copied` is high, so a single result is never captured twice.
- In IDLE, a pending `bpm_valid` is still acknowledged and then discarded. This drains the calculator; there is no history update, average or artifact count.
- Accept/reject: BPM_MIN ≤ `bpm_value` ≤ BPM_MAX → accept.
  - Accepted: the value is written into a 4-entry ring at the write pointer (2-bit, wraps 3→0), and the fill count saturates at 4.
  - Rejected: `artifact_cnt`+1, saturating at 255. History, timeout counter and state are unchanged.
- Average: computed when the fill count after the insert is 4.
  - 10-bit sum of the 4 entries, `avg_bpm` = sum>>2 (truncating).
  - Uses the new sample, not the stale ring contents.
  - No output is produced in ARMED.
- Output handshake:
  - A transfer happens when `avg_valid` and `avg_ready` are both high at a clock edge; `avg_valid` then drops unless a new average loads at the same edge.
  - If a new average loads while `avg_valid`=1 and `avg_ready`=0: `avg_bpm` is overwritten with the new value, `avg_valid` stays 1, and `overrun` is set.
  - If the load coincides with `avg_ready`=1: the old value transfers, the new value loads, and `avg_valid` stays 1 with no overrun.
- Timeout:
  - The counter increments on `sample_tick` in ARMED and RUN and resets to 0 on every accepted sample.
  - When the count reaches TIMEOUT_TICKS: `no_pulse`=1, history and fill count are cleared, the counter resets to 0, the state goes to ARMED, and a pending `avg_valid` is dropped.
  - `no_pulse` clears on the next accepted sample.
  - If an accepted capture and the timeout-reaching tick occur in the same cycle, the capture wins: the counter resets and there is no timeout.
- `stop`: `calc_en`, `avg_valid`, history and the timeout counter are cleared. `artifact_cnt`, `no_pulse` and `overrun` hold their values until the next `start`.

## Timing
- Reset: the state is IDLE and every output is 0 (`calc_en`, `bpm_copied`, `avg_bpm`, `avg_valid`, `no_pulse`, `overrun`, `artifact_cnt`). The ring contents, pointer, fill count and timeout counter are also 0.
- `bpm_valid` sampled high at edge N:
  - `bpm_copied`=1 during cycle N+1 (registered); the calculator clears `bpm_valid` at edge N+2.
  - `avg_bpm`/`avg_valid` update at edge N+1, so the controller adds one cycle of latency.
- `start` at edge N → `calc_en`=1 from cycle N+1. `stop` at edge N → `calc_en`=0 and `avg_valid`=0 from cycle N+1.
- The `no_pulse` update registers at the same edge as the tick that reaches TIMEOUT_TICKS.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Start, then beats 60, 62, 64, 66 → no output for the first three; `avg_bpm`=63 with `avg_valid` one cycle after the 4th capture. A following 70 → 65.
- With the history full (RUN), inject 250 and then 20 → two single-cycle `bpm_copied` pulses, `artifact_cnt`=2, `avg_valid` not re-asserted, history unchanged.
- Hold `avg_ready`=0 across two averages (63, then 65) → `avg_bpm`=65, `overrun`=1. Then assert `avg_ready` with a new capture at the same edge → old value transfers, `avg_valid` stays 1, no further overrun.
- In RUN, send 75 `sample_tick` with no beats → `no_pulse`=1, state ARMED, `avg_valid`=0. The next three beats give no output; the next accepted beat clears `no_pulse`.
- Assert `stop` while `bpm_valid`=1 and `avg_valid`=1 → `calc_en`=0 and `avg_valid`=0 next cycle; `bpm_copied` pulses once and `artifact_cnt` is unchanged. Asserting `start` with `stop` in the same cycle leaves the block in IDLE.
- Assert `rst` mid-RUN with `bpm_copied` high → all outputs 0 immediately (asynchronous) and the state is IDLE.
